// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - pipeline store request and data-memory port bundle for store_unit
interface store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  store_mode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        misaligned;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output st_valid, store_mode, st_addr, st_data, mem_ack, mem_rdata,
    input  st_ready, misaligned, busy, mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );

  modport slave (
    input  st_valid, store_mode, st_addr, st_data, mem_ack, mem_rdata,
    output st_ready, misaligned, busy, mem_addr, mem_wdata, mem_be, mem_we, mem_re
  );
endinterface

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store aligner, in-order store FIFO and memory drain FSM with optional RMW
module store_unit #(
  parameter int DEPTH = 2,
  parameter bit RMW   = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  store_unit_if.slave   bus_io
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t      fifo_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, count, nxt_rd;
  logic        full, empty, accept, align_ok, push, pop, start, head_valid_n;
  entry_t      in_e, head_n;
  logic [31:0] head_wdata, merge;
  logic [3:0]  head_be;
  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d, misaligned_q;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign accept = bus_io.st_valid & bus_io.st_ready;
  assign push   = accept & align_ok;
  assign pop    = (state_q == WRITE) & bus_io.mem_ack;
  assign start  = (state_q == IDLE) | pop;

  // Big-endian lanes: byte offset 0 lands in bits 31:24.
  always_comb begin
    in_e.waddr = bus_io.st_addr[31:2];
    in_e.wdata = bus_io.st_data;
    in_e.be    = 4'b1111;
    align_ok   = 1'b0;
    case (bus_io.store_mode)
      2'd0: align_ok = (bus_io.st_addr[1:0] == 2'b00);
      2'd1: begin
        in_e.wdata = {2{bus_io.st_data[15:0]}};
        in_e.be    = bus_io.st_addr[1] ? 4'b0011 : 4'b1100;
        align_ok   = ~bus_io.st_addr[0];
      end
      2'd2: begin
        in_e.wdata = {4{bus_io.st_data[7:0]}};
        in_e.be    = 4'b1000 >> bus_io.st_addr[1:0];
        align_ok   = 1'b1;
      end
      default: align_ok = 1'b0;
    endcase
  end

  // Head as seen after this cycle's pop/push; an entry pushed into an emptying FIFO is forwarded.
  assign nxt_rd       = rd_ptr_q + (AW+1)'(pop);
  assign head_valid_n = (nxt_rd != wr_ptr_q) | push;
  assign head_n       = (push && nxt_rd == wr_ptr_q) ? in_e : fifo_q[nxt_rd[AW-1:0]];
  assign head_wdata   = fifo_q[rd_ptr_q[AW-1:0]].wdata;
  assign head_be      = fifo_q[rd_ptr_q[AW-1:0]].be;

  always_comb begin
    merge = bus_io.mem_rdata;
    for (int i = 0; i < 4; i++)
      if (head_be[i]) merge[i*8 +: 8] = head_wdata[i*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= in_e;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      misaligned_q <= accept & ~align_ok;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READ:    if (bus_io.mem_ack) state_d = WRITE;
      default: begin
        if (start) begin
          if (!head_valid_n)                        state_d = IDLE;
          else if (!RMW || head_n.be == 4'b1111)    state_d = WRITE;
          else                                      state_d = READ;
        end
      end
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = (state_d == WRITE);
    mem_re_d    = (state_d == READ);
    if (start && head_valid_n) begin
      mem_addr_d  = {head_n.waddr, 2'b00};
      mem_wdata_d = head_n.wdata;
      mem_be_d    = head_n.be;
    end else if (state_q == READ && bus_io.mem_ack) begin
      mem_wdata_d = merge;
      mem_be_d    = 4'b1111;
    end
  end

  assign bus_io.st_ready   = ~full & ~rst_i;
  assign bus_io.misaligned = misaligned_q;
  assign bus_io.busy       = ~empty | (state_q != IDLE);
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = mem_wdata_q;
  assign bus_io.mem_be     = mem_be_q;
  assign bus_io.mem_we     = mem_we_q;
  assign bus_io.mem_re     = mem_re_q;
endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit, one instance per RMW setting
module tb_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_unit_if ifa ();
  store_unit_if ifb ();

  store_unit #(.DEPTH(2), .RMW(1'b0)) dut_a (.clk_i(clk), .rst_i(rst), .bus_io(ifa));
  store_unit #(.DEPTH(2), .RMW(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .bus_io(ifb));

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t         qa[$], qb[$];
  logic [31:0] rdq_b[$];
  wr_t         ea, eb;
  logic [31:0] er;
  int n_chk = 0, n_err = 0;
  int we_cnt_a = 0, we_cnt_b = 0, base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got 0x%08h expected no event", name, act);
  endtask

  // Monitor: every acked memory request is matched against the head of the expectation queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.mem_we && ifa.mem_ack) begin
        we_cnt_a++;
        if (qa.size() == 0) miss("a_unexpected_write", ifa.mem_addr);
        else begin
          ea = qa.pop_front();
          chk("a_wr_addr", ifa.mem_addr, ea.a);
          chk("a_wr_data", ifa.mem_wdata, ea.d);
          chk("a_wr_be", {28'b0, ifa.mem_be}, {28'b0, ea.be});
        end
      end
      if (ifb.mem_we && ifb.mem_ack) begin
        we_cnt_b++;
        if (qb.size() == 0) miss("b_unexpected_write", ifb.mem_addr);
        else begin
          eb = qb.pop_front();
          chk("b_wr_addr", ifb.mem_addr, eb.a);
          chk("b_wr_data", ifb.mem_wdata, eb.d);
          chk("b_wr_be", {28'b0, ifb.mem_be}, {28'b0, eb.be});
        end
      end
      if (ifb.mem_re && ifb.mem_ack) begin
        if (rdq_b.size() == 0) miss("b_unexpected_read", ifb.mem_addr);
        else begin
          er = rdq_b.pop_front();
          chk("b_rd_addr", ifb.mem_addr, er);
        end
      end
      if (ifa.mem_we && ifa.mem_re) miss("a_we_and_re", 32'h3);
      if (ifb.mem_we && ifb.mem_re) miss("b_we_and_re", 32'h3);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    if (u == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic store(input int u, input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    bit   done = 1'b0;
    logic rdy;
    if (u == 0) begin
      ifa.st_valid = 1'b1; ifa.store_mode = m; ifa.st_addr = a; ifa.st_data = d;
    end else begin
      ifb.st_valid = 1'b1; ifb.store_mode = m; ifb.st_addr = a; ifb.st_data = d;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = (u == 0) ? ifa.st_ready : ifb.st_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    if (u == 0) ifa.st_valid = 1'b0;
    else ifb.st_valid = 1'b0;
    if (!done) miss("store_accept_timeout", a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    ifa.st_valid = 0; ifa.store_mode = 0; ifa.st_addr = 0; ifa.st_data = 0; ifa.mem_ack = 0; ifa.mem_rdata = 0;
    ifb.st_valid = 0; ifb.store_mode = 0; ifb.st_addr = 0; ifb.st_data = 0; ifb.mem_ack = 0; ifb.mem_rdata = 0;

    @(negedge clk);
    chk("a_rst_ctl", {27'b0, ifa.mem_we, ifa.mem_re, ifa.misaligned, ifa.busy, ifa.st_ready}, 32'h0);
    chk("a_rst_bus", ifa.mem_addr | ifa.mem_wdata | {28'b0, ifa.mem_be}, 32'h0);
    chk("b_rst_ctl", {27'b0, ifb.mem_we, ifb.mem_re, ifb.misaligned, ifb.busy, ifb.st_ready}, 32'h0);
    chk("b_rst_bus", ifb.mem_addr | ifb.mem_wdata | {28'b0, ifb.mem_be}, 32'h0);
    sync();
    rst = 1'b0;
    cyc(1);

    // SB with ack held: single write cycle, one cycle after accept
    ifa.mem_ack = 1'b1;
    base = we_cnt_a;
    expect_wr(0, 32'h100, 32'hABABABAB, 4'b0100);
    store(0, 2'd2, 32'h101, 32'hAB);
    @(negedge clk);
    chk("t1_we_latency", {31'b0, ifa.mem_we}, 32'h1);
    cyc(3);
    chk("t1_we_cycles", we_cnt_a - base, 1);

    // SH aligned, then misaligned SH and reserved mode are dropped
    base = we_cnt_a;
    expect_wr(0, 32'h200, 32'h12341234, 4'b0011);
    store(0, 2'd1, 32'h202, 32'h1234);
    store(0, 2'd1, 32'h203, 32'h5678);
    @(negedge clk);
    chk("t2_misaligned_pulse", {31'b0, ifa.misaligned}, 32'h1);
    @(negedge clk);
    chk("t2_misaligned_clear", {31'b0, ifa.misaligned}, 32'h0);
    sync();
    store(0, 2'd3, 32'h300, 32'h0);
    @(negedge clk);
    chk("t2_mode3_pulse", {31'b0, ifa.misaligned}, 32'h1);
    cyc(3);
    chk("t2_we_count", we_cnt_a - base, 1);
    chk("t2_idle", {31'b0, ifa.busy}, 32'h0);

    // Back-to-back accepts with ack held: one store per cycle
    base = we_cnt_a;
    expect_wr(0, 32'h400, 32'h11111111, 4'b1000);
    expect_wr(0, 32'h400, 32'h22222222, 4'b0100);
    expect_wr(0, 32'h404, 32'h33333333, 4'b0010);
    store(0, 2'd2, 32'h400, 32'h11);
    store(0, 2'd2, 32'h401, 32'h22);
    store(0, 2'd2, 32'h406, 32'h33);
    chk("t3_b2b_inflight", we_cnt_a - base, 2);
    cyc(3);
    chk("t3_b2b_total", we_cnt_a - base, 3);

    // Full FIFO: third SW held until one ack pops the head
    ifa.mem_ack = 1'b0;
    base = we_cnt_a;
    expect_wr(0, 32'h10, 32'h01010101, 4'b1111);
    expect_wr(0, 32'h14, 32'h02020202, 4'b1111);
    expect_wr(0, 32'h18, 32'h03030303, 4'b1111);
    store(0, 2'd0, 32'h10, 32'h01010101);
    store(0, 2'd0, 32'h14, 32'h02020202);
    fork
      store(0, 2'd0, 32'h18, 32'h03030303);
      begin
        @(negedge clk);
        chk("t4_full_not_ready", {31'b0, ifa.st_ready}, 32'h0);
        sync();
        ifa.mem_ack = 1'b1;
        sync();
        ifa.mem_ack = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_pop", {31'b0, ifa.st_ready}, 32'h1);
      end
    join
    chk("t4_one_written", we_cnt_a - base, 1);
    ifa.mem_ack = 1'b1;
    cyc(4);
    chk("t4_all_written", we_cnt_a - base, 3);
    chk("t4_queue_drained", qa.size(), 0);

    // RMW: partial byte store reads, merges, writes full word
    ifb.mem_ack = 1'b1;
    ifb.mem_rdata = 32'h11223344;
    rdq_b.push_back(32'h4);
    expect_wr(1, 32'h4, 32'h1122335A, 4'b1111);
    store(1, 2'd2, 32'h7, 32'h5A);
    @(negedge clk);
    chk("t5_read_first", {30'b0, ifb.mem_re, ifb.mem_we}, 32'h2);
    @(negedge clk);
    chk("t5_write_second", {30'b0, ifb.mem_re, ifb.mem_we}, 32'h1);
    cyc(2);
    chk("t5_reads_done", rdq_b.size(), 0);

    // RMW: full word goes straight to write and holds through ack latency
    ifb.mem_ack = 1'b0;
    base = we_cnt_b;
    expect_wr(1, 32'h10, 32'hCAFEF00D, 4'b1111);
    store(1, 2'd0, 32'h10, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_hold_ctl", {30'b0, ifb.mem_re, ifb.mem_we}, 32'h1);
      chk("t6_hold_addr", ifb.mem_addr, 32'h10);
      chk("t6_hold_data", ifb.mem_wdata, 32'hCAFEF00D);
      chk("t6_hold_be", {28'b0, ifb.mem_be}, 32'hF);
    end
    sync();
    ifb.mem_ack = 1'b1;
    sync();
    ifb.mem_ack = 1'b0;
    cyc(1);
    chk("t6_one_write", we_cnt_b - base, 1);
    chk("t6_queue_drained", qb.size(), 0);

    // Reset while writing with two queued drops everything immediately
    ifa.mem_ack = 1'b0;
    expect_wr(0, 32'h40, 32'h0, 4'b1111);
    expect_wr(0, 32'h44, 32'h0, 4'b1111);
    store(0, 2'd0, 32'h40, 32'h0);
    store(0, 2'd0, 32'h44, 32'h0);
    @(negedge clk);
    chk("t7_pre_we", {31'b0, ifa.mem_we}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_we", {31'b0, ifa.mem_we}, 32'h0);
    chk("t7_rst_busy", {31'b0, ifa.busy}, 32'h0);
    qa.delete();
    sync();
    rst = 1'b0;
    ifa.mem_ack = 1'b1;
    cyc(3);
    chk("t7_post_ctl", {29'b0, ifa.mem_we, ifa.busy, ifa.st_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
